latch_dump_tx: RTL and testbench

//  Captures a snapshot of the four pipeline latches (IF_ID, ID_EX, EX_MEM, MEM_WB) on request and streams it out as a byte frame.

---
 rtl/latch_dump_tx_pkg.sv | 23 ++
 rtl/latch_dump_tx_shift_reg.sv | 29 ++
 rtl/latch_dump_tx.sv | 118 +++++++++++
 tb/tb_latch_dump_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_dump_tx_pkg.sv
// Shared definitions for the pipeline latch dump transmitter: FSM encoding,
// default frame header and snapshot size derivation.
package latch_dump_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    function automatic int calc_nb_snap(input int nb_if_id, input int nb_id_ex,
                                        input int nb_ex_mem, input int nb_mem_wb);
        return nb_if_id + nb_id_ex + nb_ex_mem + nb_mem_wb;
    endfunction

    function automatic int calc_n_bytes(input int nb_snap, input int nb_data);
        return nb_snap / nb_data;
    endfunction

endpackage

// File: rtl/latch_dump_tx_shift_reg.sv
// Snapshot register: parallel load of the whole latch set, then shifts out
// one byte at a time from the MSB end.
module dump_shift_reg #(
    parameter int NB_SNAP = 360,
    parameter int NB_DATA = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic               i_shift,
    input  logic [NB_SNAP-1:0] i_snap,
    output logic [NB_DATA-1:0] o_top_byte
);

    logic [NB_SNAP-1:0] shift_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            shift_q <= '0;
        end else if (i_load) begin
            shift_q <= i_snap;
        end else if (i_shift) begin
            shift_q <= shift_q << NB_DATA;
        end
    end

    assign o_top_byte = shift_q[NB_SNAP-1 -: NB_DATA];

endmodule

// File: rtl/latch_dump_tx.sv
// Captures the four pipeline latches on request and streams them to uart_tx
// as a frame: header, latch bytes (MSB first), XOR checksum.
//
//  state | meaning
//  IDLE  | waiting for i_start; snapshot taken on the accepting edge
//  SEND  | o_tx_start high for this cycle, o_tx_data holds the byte
//  WAIT  | waiting for uart_tx to report the byte complete
//  DONE  | o_done pulse, o_busy released on exit
module latch_dump_tx
    import latch_dump_tx_pkg::*;
#(
    parameter int                 NB_DATA   = 8,
    parameter int                 NB_IF_ID  = 64,
    parameter int                 NB_ID_EX  = 144,
    parameter int                 NB_EX_MEM = 80,
    parameter int                 NB_MEM_WB = 72,
    parameter logic [NB_DATA-1:0] HEADER    = NB_DATA'(HEADER_DEFAULT)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [NB_IF_ID-1:0]  i_IF_ID,
    input  logic [NB_ID_EX-1:0]  i_ID_EX,
    input  logic [NB_EX_MEM-1:0] i_EX_MEM,
    input  logic [NB_MEM_WB-1:0] i_MEM_WB,
    input  logic                 i_tx_done,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int NB_SNAP = calc_nb_snap(NB_IF_ID, NB_ID_EX, NB_EX_MEM, NB_MEM_WB);
    localparam int N_BYTES = calc_n_bytes(NB_SNAP, NB_DATA);
    localparam int NB_CNT  = $clog2(N_BYTES + 2);

    // Counter value at which the checksum byte is next, and the final value.
    localparam logic [NB_CNT-1:0] CNT_CSUM = NB_CNT'(N_BYTES);

    state_t              state;
    logic [NB_DATA-1:0]  checksum;
    logic [NB_CNT-1:0]   byte_cnt;
    logic [NB_DATA-1:0]  top_byte;
    logic                snap_load;
    logic                snap_shift;

    assign snap_load  = (state == ST_IDLE) && i_start;
    assign snap_shift = (state == ST_WAIT) && i_tx_done && (byte_cnt < CNT_CSUM);

    dump_shift_reg #(
        .NB_SNAP (NB_SNAP),
        .NB_DATA (NB_DATA)
    ) u_shift (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (snap_load),
        .i_shift    (snap_shift),
        .i_snap     ({i_IF_ID, i_ID_EX, i_EX_MEM, i_MEM_WB}),
        .o_top_byte (top_byte)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= ST_IDLE;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            checksum   <= '0;
            byte_cnt   <= '0;
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        o_tx_data  <= HEADER;
                        checksum   <= '0;
                        byte_cnt   <= '0;
                        o_busy     <= 1'b1;
                        o_tx_start <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (byte_cnt < CNT_CSUM) begin
                            o_tx_data  <= top_byte;
                            checksum   <= checksum ^ top_byte;
                            byte_cnt   <= byte_cnt + 1'b1;
                            o_tx_start <= 1'b1;
                            state      <= ST_SEND;
                        end else if (byte_cnt == CNT_CSUM) begin
                            o_tx_data  <= checksum;
                            byte_cnt   <= byte_cnt + 1'b1;
                            o_tx_start <= 1'b1;
                            state      <= ST_SEND;
                        end else begin
                            o_done <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_dump_tx.sv
// Scoreboard bench for latch_dump_tx: frames are pushed as expected bytes,
// a monitor pops and compares on every o_tx_start.
module tb_latch_dump_tx;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [63:0]  if_id;
    logic [143:0] id_ex;
    logic [79:0]  ex_mem;
    logic [71:0]  mem_wb;
    logic         tx_done;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         busy;
    logic         done;

    logic resp_done;
    logic glitch_done;
    logic idle_done;
    logic glitch_en;
    logic prev_start;

    int n_tests;
    int n_fail;
    int done_cnt;

    logic [7:0] exp_q[$];
    logic [7:0] seen_q[$];

    assign tx_done = resp_done | glitch_done | idle_done;

    latch_dump_tx dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_start    (start),
        .i_IF_ID    (if_id),
        .i_ID_EX    (id_ex),
        .i_EX_MEM   (ex_mem),
        .i_MEM_WB   (mem_wb),
        .i_tx_done  (tx_done),
        .o_tx_data  (tx_data),
        .o_tx_start (tx_start),
        .o_busy     (busy),
        .o_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [359:0] snap);
        logic [7:0] b;
        logic [7:0] cs;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 45; i++) begin
            b = snap[359 - 8*i -: 8];
            cs = cs ^ b;
            exp_q.push_back(b);
        end
        exp_q.push_back(cs);
    endtask

    task automatic set_latches(input logic [359:0] snap);
        if_id  = snap[359:296];
        id_ex  = snap[295:152];
        ex_mem = snap[151:72];
        mem_wb = snap[71:0];
    endtask

    // Scoreboard monitor: every start pulse consumes one expected byte.
    always @(negedge clk) begin
        if (tx_start) begin
            seen_q.push_back(tx_data);
            check("start_one_cycle", 64'(prev_start), 64'd0);
            check("busy_during_tx", 64'(busy), 64'd1);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_byte: actual %0h required no start", tx_data);
            end else begin
                check("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
            end
        end
        if (done) done_cnt++;
        prev_start = tx_start;
    end

    // uart_tx model: byte complete 3 cycles after each start.
    initial begin
        resp_done   = 1'b0;
        glitch_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                glitch_done = glitch_en;
                @(posedge clk); #1 glitch_done = 1'b0;
                @(posedge clk); #1 resp_done = 1'b1;
                @(posedge clk); #1 resp_done = 1'b0;
            end
        end
    end

    task automatic do_frame(input string name, input logic [359:0] snap,
                            input bit hold, input bit mutate, input bit glitch);
        int base_done;
        bit got;
        base_done = done_cnt;
        seen_q.delete();
        push_frame(snap);
        set_latches(snap);
        glitch_en = glitch;
        if (glitch) begin
            @(posedge clk); #1 idle_done = 1'b1;
            @(posedge clk); #1 idle_done = 1'b0;
        end
        @(posedge clk); #1 start = 1'b1;
        if (!hold) begin
            @(posedge clk); #1 start = 1'b0;
        end
        if (mutate) begin
            got = 0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(posedge clk);
                if (seen_q.size() >= 1) got = 1;
            end
            #1 set_latches({360{1'b1}});
        end
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(posedge clk);
            if (done_cnt != base_done) got = 1;
        end
        check({name, "_done_seen"}, 64'(got), 64'd1);
        #1 start = 1'b0;
        glitch_en = 1'b0;
        set_latches('0);
        repeat (20) @(posedge clk);
        #1;
        check({name, "_start_count"}, 64'(seen_q.size()), 64'd47);
        check({name, "_done_count"}, 64'(done_cnt - base_done), 64'd1);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check({name, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int base_done;
        bit got;
        n_tests   = 0;
        n_fail    = 0;
        done_cnt  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        idle_done = 1'b0;
        glitch_en = 1'b0;
        prev_start = 1'b0;
        set_latches('0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_tx_start", 64'(tx_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Reset during WAIT of byte 10 aborts without o_done.
        base_done = done_cnt;
        seen_q.delete();
        push_frame({64'h0123456789ABCDEF, {9{16'hBEEF}}, 80'h13579BDF02468ACE1357, 72'hFEDCBA987654321000});
        set_latches({64'h0123456789ABCDEF, {9{16'hBEEF}}, 80'h13579BDF02468ACE1357, 72'hFEDCBA987654321000});
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        got = 0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(posedge clk);
            if (seen_q.size() >= 11) got = 1;
        end
        check("abort_reached_byte10", 64'(got), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_tx_data", 64'(tx_data), 64'd0);
        check("abort_tx_start", 64'(tx_start), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("abort_no_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (10) @(posedge clk);
        #1;
        check("abort_done_count", 64'(done_cnt - base_done), 64'd0);
        check("abort_no_more_bytes", 64'(seen_q.size()), 64'd11);
        do_frame("after_reset",
                 {64'h0123456789ABCDEF, {9{16'hBEEF}}, 80'h13579BDF02468ACE1357, 72'hFEDCBA987654321000},
                 1'b0, 1'b0, 1'b0);

        // IF_ID pattern only: checksum of 00..77 is zero.
        do_frame("if_id", {64'h0011223344556677, 296'd0}, 1'b0, 1'b0, 1'b0);
        check("if_id_byte1", 64'(seen_q[1]), 64'h00);
        check("if_id_byte2", 64'(seen_q[2]), 64'h11);
        check("if_id_byte8", 64'(seen_q[8]), 64'h77);
        check("if_id_byte9", 64'(seen_q[9]), 64'h00);
        check("if_id_checksum", 64'(seen_q[46]), 64'h00);

        // MEM_WB pattern: last latch byte 80, checksum 01^80 = 81.
        do_frame("mem_wb", {288'd0, 72'h01_0000_0000_0000_0080}, 1'b0, 1'b0, 1'b0);
        check("mem_wb_byte37", 64'(seen_q[37]), 64'h01);
        check("mem_wb_byte45", 64'(seen_q[45]), 64'h80);
        check("mem_wb_checksum", 64'(seen_q[46]), 64'h81);

        // i_start held through the frame and the DONE cycle.
        do_frame("hold_start", {64'hA0A1A2A3A4A5A6A7, 296'd0}, 1'b1, 1'b0, 1'b0);
        check("hold_checksum", 64'(seen_q[46]), 64'h00);

        // Spurious i_tx_done in IDLE and in each SEND cycle.
        do_frame("glitch_done", {64'h1122334455667788, 224'd0, 72'h000000000000000001}, 1'b0, 1'b0, 1'b1);
        check("glitch_checksum", 64'(seen_q[46]), 64'h89);

        // Latches forced to all-ones after the header goes out.
        do_frame("mutate", {64'h00000000000000F0, 296'd0}, 1'b0, 1'b1, 1'b0);
        check("mutate_byte8", 64'(seen_q[8]), 64'hF0);
        check("mutate_byte20", 64'(seen_q[20]), 64'h00);
        check("mutate_checksum", 64'(seen_q[46]), 64'hF0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
